// File: rtl/ahbaxi_pkg.sv
// ahbaxi_pkg: shared FSM states and AHB/AXI encodings for ahb_axi_bridge
package ahbaxi_pkg;
  typedef enum logic [2:0] {IDLE, WDATA, WADDR, WRESP, RADDR, RDATA, ERR1, ERR2} state_t;
  typedef enum logic [1:0] {HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ} htrans_t;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
endpackage

// File: rtl/ahb_axi_bridge.sv
// ahb_axi_bridge: AHB-Lite slave to single-beat AXI4 master, one transfer in flight; AHB_AXI_POSTED_WRITE_EN selects posted writes
module ahb_axi_bridge
  import ahbaxi_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH = 56,
  parameter int AXI_ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic HSEL,
  input  logic HWRITE,
  input  logic HREADY,
  input  logic [AHB_ADDR_WIDTH-1:0] HADDR,
  input  logic [2:0] HSIZE,
  input  logic [2:0] HBURST,
  input  logic [1:0] HTRANS,
  input  logic [3:0] HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH/8-1:0] HWSTRB,
  output logic HREADYOUT,
  output logic HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic [ID_WIDTH-1:0] m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0] m_axi_awlen,
  output logic [2:0] m_axi_awsize,
  output logic [1:0] m_axi_awburst,
  output logic m_axi_awlock,
  output logic [3:0] m_axi_awcache,
  output logic [2:0] m_axi_awprot,
  output logic m_axi_awvalid,
  input  logic m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic m_axi_wlast,
  output logic m_axi_wvalid,
  input  logic m_axi_wready,
  input  logic [ID_WIDTH-1:0] m_axi_bid,
  input  logic [1:0] m_axi_bresp,
  input  logic m_axi_bvalid,
  output logic m_axi_bready,
  output logic [ID_WIDTH-1:0] m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0] m_axi_arlen,
  output logic [2:0] m_axi_arsize,
  output logic [1:0] m_axi_arburst,
  output logic m_axi_arlock,
  output logic [3:0] m_axi_arcache,
  output logic [2:0] m_axi_arprot,
  output logic m_axi_arvalid,
  input  logic m_axi_arready,
  input  logic [ID_WIDTH-1:0] m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0] m_axi_rresp,
  input  logic m_axi_rlast,
  input  logic m_axi_rvalid,
  output logic m_axi_rready
);
  state_t state, state_n;
  logic hold, aw_done, w_done, write;
  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [2:0] size, prot;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic cap, aw_ok, w_ok, both_ok, b_wait, start_ok;
  logic unused;
  assign cap = HSEL & HREADY & HREADYOUT & (HTRANS inside {HTRANS_NONSEQ, HTRANS_SEQ});
  assign aw_ok = aw_done | (m_axi_awvalid & m_axi_awready);
  assign w_ok = w_done | (m_axi_wvalid & m_axi_wready);
  assign both_ok = (state == WADDR) & aw_ok & w_ok;
  assign start_ok = (cap | hold) & ~b_wait;
  assign HREADYOUT = ((state == IDLE) & ~hold) | (state == ERR2);
  assign HRESP = (state == ERR1) | (state == ERR2);
  assign m_axi_awid = '0;
  assign m_axi_arid = '0;
  assign m_axi_awlen = 8'd0;
  assign m_axi_arlen = 8'd0;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_awlock = 1'b0;
  assign m_axi_arlock = 1'b0;
  assign m_axi_awcache = AXI_CACHE_DEFAULT;
  assign m_axi_arcache = AXI_CACHE_DEFAULT;
  assign m_axi_awaddr = addr;
  assign m_axi_araddr = addr;
  assign m_axi_awsize = size;
  assign m_axi_arsize = size;
  assign m_axi_awprot = prot;
  assign m_axi_arprot = prot;
  assign m_axi_wdata = wdata;
  assign m_axi_wstrb = wstrb;
  assign m_axi_wlast = 1'b1;
  assign m_axi_awvalid = (state == WADDR) & ~aw_done;
  assign m_axi_wvalid = (state == WADDR) & ~w_done;
  assign m_axi_arvalid = state == RADDR;
  assign m_axi_rready = state == RDATA;
  assign unused = &{1'b0, HBURST, HPROT[3:2], HADDR[AHB_ADDR_WIDTH-1:AXI_ADDR_WIDTH], m_axi_bid, m_axi_rid, m_axi_rlast};
`ifdef AHB_AXI_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
  logic b_pend;
  // one posted B response outstanding; it is absorbed whenever it arrives
  always_ff @(posedge clk) b_pend <= reset ? 1'b0 : both_ok | (b_pend & ~m_axi_bvalid);
  assign b_wait = b_pend & ~m_axi_bvalid;
  assign m_axi_bready = b_pend;
`else
  localparam bit POSTED = 1'b0;
  assign b_wait = 1'b0;
  assign m_axi_bready = state == WRESP;
`endif
  // next-state: IDLE and ERR2 both accept a pipelined address phase
  always_comb begin
    state_n = state;
    case (state)
      IDLE, ERR2: state_n = start_ok ? ((cap ? HWRITE : write) ? WDATA : RADDR) : IDLE;
      WDATA: state_n = WADDR;
      WADDR: state_n = (aw_ok & w_ok) ? (POSTED ? IDLE : WRESP) : WADDR;
      WRESP: state_n = m_axi_bvalid ? (|(m_axi_bresp & AXI_RESP_SLVERR) ? ERR1 : IDLE) : WRESP;
      RADDR: state_n = m_axi_arready ? RDATA : RADDR;
      RDATA: state_n = m_axi_rvalid ? (|(m_axi_rresp & AXI_RESP_SLVERR) ? ERR1 : IDLE) : RDATA;
      ERR1: state_n = ERR2;
      default: state_n = IDLE;
    endcase
  end
  // state register plus per-channel handshake tracking while in WADDR
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hold <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      state <= state_n;
      hold <= (cap | hold) & b_wait;
      aw_done <= (state_n == WADDR) & aw_ok;
      w_done <= (state_n == WADDR) & w_ok;
    end
  end
  // address-phase capture, write data capture and read data return
  always_ff @(posedge clk) begin
    if (reset) begin
      HRDATA <= '0;
    end else begin
      if (cap) begin
        addr <= HADDR[AXI_ADDR_WIDTH-1:0];
        write <= HWRITE;
        size <= HSIZE;
        prot <= {~HPROT[0], 1'b0, HPROT[1]};
      end
      if (state == WDATA) begin
        wdata <= HWDATA;
        wstrb <= HWSTRB;
      end
      if ((state == RDATA) & m_axi_rvalid) HRDATA <= m_axi_rdata;
    end
  end
endmodule

// File: tb/tb_ahb_axi_bridge.sv
// tb_ahb_axi_bridge: directed checks of ahb_axi_bridge against a reactive AXI slave
module tb_ahb_axi_bridge;
  import ahbaxi_pkg::*;
  logic clk = 1'b0, reset;
  logic HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [55:0] HADDR;
  logic [2:0] HSIZE, HBURST;
  logic [1:0] HTRANS;
  logic [3:0] HPROT;
  logic [63:0] HWDATA, HRDATA;
  logic [7:0] HWSTRB;
  logic [3:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [30:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0] m_axi_awlen, m_axi_arlen, m_axi_wstrb;
  logic [2:0] m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0] m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic m_axi_awlock, m_axi_arlock, m_axi_wlast, m_axi_rlast;
  logic [3:0] m_axi_awcache, m_axi_arcache;
  logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
  logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic [63:0] m_axi_wdata, m_axi_rdata;
  int vectors = 0, miscompares = 0, cyc = 0;
  int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait_cfg = 0, r_wait = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [63:0] rdata_cfg = '0;
  int aw_n, w_n, ar_n, b_n, r_n, aw_held, w_held, ar_held, ar_first_cyc, b_fire_cyc, overlap;
  logic aw_f, w_f, ar_f, b_f, r_f, aw_ok_t, w_ok_t, b_due, r_due, wlast_q;
  logic [30:0] aw_addr_q, ar_addr_q;
  logic [2:0] aw_size_q, ar_size_q, ar_prot_q;
  logic [7:0] wstrb_q;
  logic [63:0] wdata_q;

  assign HREADY = HREADYOUT;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ahb_axi_bridge dut (
    .clk(clk), .reset(reset), .HSEL(HSEL), .HWRITE(HWRITE), .HREADY(HREADY), .HADDR(HADDR),
    .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HPROT(HPROT), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // AXI slave: inputs change on negedge, handshakes land on the following posedge
  initial begin
    {m_axi_awready, m_axi_wready, m_axi_arready, m_axi_bvalid, m_axi_rvalid} = '0;
    m_axi_bresp = 2'b00; m_axi_rresp = 2'b00; m_axi_rdata = '0; m_axi_rlast = 1'b1;
    m_axi_bid = '0; m_axi_rid = '0;
    {aw_f, w_f, ar_f, b_f, r_f, aw_ok_t, w_ok_t, b_due, r_due} = '0;
    {aw_n, w_n, ar_n, b_n, r_n, aw_held, w_held, ar_held, ar_first_cyc, b_fire_cyc, overlap} = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        {m_axi_awready, m_axi_wready, m_axi_arready, m_axi_bvalid, m_axi_rvalid} = '0;
        {aw_f, w_f, ar_f, b_f, r_f, aw_ok_t, w_ok_t, b_due, r_due} = '0;
        {aw_n, w_n, ar_n, b_n, r_n} = '0;
      end else begin
        if (aw_f) aw_ok_t = 1'b1;
        if (w_f) w_ok_t = 1'b1;
        aw_f = 1'b0; w_f = 1'b0;
        if (aw_ok_t && w_ok_t) begin aw_ok_t = 1'b0; w_ok_t = 1'b0; b_due = 1'b1; b_n = 0; end
        if (ar_f) begin r_due = 1'b1; r_n = 0; end
        ar_f = 1'b0;
        if (b_f) m_axi_bvalid = 1'b0;
        if (r_f) m_axi_rvalid = 1'b0;
        b_f = 1'b0; r_f = 1'b0;
        if (m_axi_awvalid) begin aw_n++; m_axi_awready = aw_n > aw_wait; end else begin aw_n = 0; m_axi_awready = 1'b0; end
        if (m_axi_awvalid && m_axi_awready) begin aw_f = 1'b1; aw_held = aw_n; aw_addr_q = m_axi_awaddr; aw_size_q = m_axi_awsize; end
        if (m_axi_wvalid) begin w_n++; m_axi_wready = w_n > w_wait; end else begin w_n = 0; m_axi_wready = 1'b0; end
        if (m_axi_wvalid && m_axi_wready) begin w_f = 1'b1; w_held = w_n; wstrb_q = m_axi_wstrb; wdata_q = m_axi_wdata; wlast_q = m_axi_wlast; end
        if (m_axi_arvalid) begin
          ar_n++;
          if (ar_n == 1) ar_first_cyc = cyc;
          m_axi_arready = ar_n > ar_wait;
        end else begin ar_n = 0; m_axi_arready = 1'b0; end
        if (m_axi_arvalid && m_axi_arready) begin ar_f = 1'b1; ar_held = ar_n; ar_addr_q = m_axi_araddr; ar_size_q = m_axi_arsize; ar_prot_q = m_axi_arprot; end
        if (b_due) begin
          if (b_n >= b_wait_cfg) begin m_axi_bvalid = 1'b1; m_axi_bresp = bresp_cfg; b_due = 1'b0; end else b_n++;
        end
        if (m_axi_bvalid && m_axi_bready) begin b_f = 1'b1; b_fire_cyc = cyc; end
        if (r_due) begin
          if (r_n >= r_wait) begin m_axi_rvalid = 1'b1; m_axi_rresp = rresp_cfg; m_axi_rdata = rdata_cfg; r_due = 1'b0; end else r_n++;
        end
        if (m_axi_rvalid && m_axi_rready) r_f = 1'b1;
        if ((m_axi_awvalid || m_axi_wvalid) && m_axi_arvalid) overlap++;
      end
    end
  end

  // one AHB transfer: address phase in the current cycle, returns in the cycle HREADYOUT rises
  task automatic ahb_do(input logic wr, input logic [55:0] a, input logic [2:0] sz, input logic [63:0] d,
                        input logic [7:0] st, output int low, output logic last_resp);
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = a; HWRITE = wr; HSIZE = sz; HPROT = 4'b0011; HBURST = 3'b000;
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = d; HWSTRB = st;
    low = 0; last_resp = 1'b0;
    while (HREADYOUT !== 1'b1 && low < 100) begin
      last_resp = HRESP; low++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HADDR = '0; HSIZE = 3'd0; HBURST = 3'd0; HPROT = 4'd0; HWDATA = '0; HWSTRB = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({HREADYOUT, HRESP, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 7'b1000000) begin
      miscompares++; $display("FAIL reset_ctrl: got %b expected 1000000", {HREADYOUT, HRESP, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready});
    end
    vectors++;
    if (HRDATA !== 64'd0) begin miscompares++; $display("FAIL reset_hrdata: got %h expected 0", HRDATA); end
    vectors++;
    if ({m_axi_awid, m_axi_arid, m_axi_awlen, m_axi_arlen, m_axi_awburst, m_axi_arburst, m_axi_awlock, m_axi_arlock, m_axi_awcache, m_axi_arcache, m_axi_wlast}
        !== {4'h0, 4'h0, 8'h0, 8'h0, 2'b01, 2'b01, 1'b0, 1'b0, 4'b0011, 4'b0011, 1'b1}) begin
      miscompares++; $display("FAIL axi_constants: got id %h/%h len %h/%h burst %b/%b cache %b/%b wlast %b", m_axi_awid, m_axi_arid,
        m_axi_awlen, m_axi_arlen, m_axi_awburst, m_axi_arburst, m_axi_awcache, m_axi_arcache, m_axi_wlast);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle_busy();
    HSEL = 1'b1; HTRANS = HTRANS_BUSY; HWRITE = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({HREADYOUT, HRESP, m_axi_arvalid, m_axi_awvalid} !== 4'b1000) begin
      miscompares++; $display("FAIL busy_okay: got %b expected 1000", {HREADYOUT, HRESP, m_axi_arvalid, m_axi_awvalid});
    end
    HTRANS = HTRANS_IDLE;
    @(posedge clk); #1;
    vectors++;
    if ({HREADYOUT, HRESP, m_axi_arvalid, m_axi_awvalid} !== 4'b1000) begin
      miscompares++; $display("FAIL idle_okay: got %b expected 1000", {HREADYOUT, HRESP, m_axi_arvalid, m_axi_awvalid});
    end
    HSEL = 1'b0;
  endtask

  task automatic test_read_err();
    int low; logic lr;
    ar_wait = 0; r_wait = 0; rresp_cfg = 2'b10; rdata_cfg = 64'h5555_AAAA_5555_AAAA;
    ahb_do(1'b0, 56'h100, 3'd3, '0, '0, low, lr);
    vectors++;
    if (low !== 3) begin miscompares++; $display("FAIL rerr_low: got %0d expected 3", low); end
    vectors++;
    if (lr !== 1'b1) begin miscompares++; $display("FAIL rerr_err1_hresp: got %b expected 1", lr); end
    vectors++;
    if ({HRESP, HREADYOUT} !== 2'b11) begin miscompares++; $display("FAIL rerr_err2: got %b expected 11", {HRESP, HREADYOUT}); end
    @(posedge clk); #1;
    vectors++;
    if ({HRESP, HREADYOUT} !== 2'b01) begin miscompares++; $display("FAIL rerr_idle: got %b expected 01", {HRESP, HREADYOUT}); end
    rresp_cfg = 2'b00;
  endtask

  task automatic test_read();
    int low; logic lr;
    ar_wait = 0; r_wait = 0; rdata_cfg = 64'hDEADBEEF_CAFEF00D;
    ahb_do(1'b0, 56'h8000_0000, 3'd3, '0, '0, low, lr);
    vectors++;
    if (low !== 2) begin miscompares++; $display("FAIL read_low: got %0d expected 2", low); end
    vectors++;
    if (HRDATA !== 64'hDEADBEEF_CAFEF00D) begin miscompares++; $display("FAIL read_hrdata: got %h expected deadbeefcafef00d", HRDATA); end
    vectors++;
    if (ar_addr_q !== 31'h0) begin miscompares++; $display("FAIL read_araddr: got %h expected 0", ar_addr_q); end
    vectors++;
    if ({ar_size_q, ar_prot_q} !== {3'd3, 3'b001}) begin miscompares++; $display("FAIL read_size_prot: got %0d/%b expected 3/001", ar_size_q, ar_prot_q); end
    vectors++;
    if (HRESP !== 1'b0) begin miscompares++; $display("FAIL read_hresp: got %b expected 0", HRESP); end
  endtask

  task automatic test_reset_mid();
    aw_wait = 20; w_wait = 0;
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 56'h200; HWRITE = 1'b1; HSIZE = 3'd3;
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = 64'h1; HWSTRB = 8'hFF;
    @(posedge clk); #1;
    vectors++;
    if (m_axi_awvalid !== 1'b1) begin miscompares++; $display("FAIL rstmid_awvalid: got %b expected 1", m_axi_awvalid); end
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({HREADYOUT, HRESP, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 7'b1000000) begin
      miscompares++; $display("FAIL rstmid_ctrl: got %b expected 1000000", {HREADYOUT, HRESP, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready});
    end
    vectors++;
    if (HRDATA !== 64'd0) begin miscompares++; $display("FAIL rstmid_hrdata: got %h expected 0", HRDATA); end
    reset = 1'b0; aw_wait = 0;
    @(posedge clk); #1;
  endtask

`ifdef AHB_AXI_POSTED_WRITE_EN
  task automatic test_posted();
    int low; logic lr;
    aw_wait = 0; w_wait = 0; b_wait_cfg = 10; bresp_cfg = 2'b10; rdata_cfg = 64'hFEED_0000_0000_BEEF;
    ahb_do(1'b1, 56'h300, 3'd3, 64'h77, 8'hFF, low, lr);
    vectors++;
    if (low !== 2) begin miscompares++; $display("FAIL posted_wlow: got %0d expected 2", low); end
    vectors++;
    if (HRESP !== 1'b0) begin miscompares++; $display("FAIL posted_whresp: got %b expected 0", HRESP); end
    ahb_do(1'b0, 56'h308, 3'd3, '0, '0, low, lr);
    vectors++;
    if (low !== 12) begin miscompares++; $display("FAIL posted_rlow: got %0d expected 12", low); end
    vectors++;
    if (ar_first_cyc !== b_fire_cyc + 1) begin miscompares++; $display("FAIL posted_ar_after_b: got ar %0d b %0d expected ar=b+1", ar_first_cyc, b_fire_cyc); end
    vectors++;
    if ({HRDATA, HRESP} !== {64'hFEED_0000_0000_BEEF, 1'b0}) begin miscompares++; $display("FAIL posted_rdata: got %h/%b expected feed00000000beef/0", HRDATA, HRESP); end
    b_wait_cfg = 0; bresp_cfg = 2'b00;
  endtask
`else
  task automatic test_write();
    int low; logic lr;
    aw_wait = 3; w_wait = 0; b_wait_cfg = 0; bresp_cfg = 2'b00;
    ahb_do(1'b1, 56'h8000_0003, 3'd0, 64'h1122334455667788, 8'h08, low, lr);
    vectors++;
    if (low !== 6) begin miscompares++; $display("FAIL write_low: got %0d expected 6", low); end
    vectors++;
    if ({aw_held, w_held} !== {32'd4, 32'd1}) begin miscompares++; $display("FAIL write_held: got aw %0d w %0d expected 4/1", aw_held, w_held); end
    vectors++;
    if ({wstrb_q, wdata_q, wlast_q} !== {8'h08, 64'h1122334455667788, 1'b1}) begin
      miscompares++; $display("FAIL write_wdata: got %h/%h/%b expected 08/1122334455667788/1", wstrb_q, wdata_q, wlast_q);
    end
    vectors++;
    if ({aw_addr_q, aw_size_q} !== {31'h3, 3'd0}) begin miscompares++; $display("FAIL write_aw: got %h/%0d expected 3/0", aw_addr_q, aw_size_q); end
    vectors++;
    if (HRESP !== 1'b0) begin miscompares++; $display("FAIL write_hresp: got %b expected 0", HRESP); end
    vectors++;
    if (HRDATA !== 64'hDEADBEEF_CAFEF00D) begin miscompares++; $display("FAIL write_hrdata_hold: got %h expected deadbeefcafef00d", HRDATA); end
    aw_wait = 0;
  endtask

  task automatic test_write_err();
    int low; logic lr;
    bresp_cfg = 2'b10;
    ahb_do(1'b1, 56'h10, 3'd2, 64'h9, 8'h0F, low, lr);
    vectors++;
    if ({low, lr, HRESP} !== {32'd4, 1'b1, 1'b1}) begin miscompares++; $display("FAIL werr: got low %0d err1 %b err2 %b expected 4/1/1", low, lr, HRESP); end
    @(posedge clk); #1;
    bresp_cfg = 2'b00;
  endtask

  task automatic test_back_to_back();
    int low, done; logic lr;
    overlap = 0; rdata_cfg = 64'h0123456789ABCDEF;
    ahb_do(1'b1, 56'h40, 3'd3, 64'hA5, 8'hFF, low, lr);
    done = cyc;
    vectors++;
    if (low !== 3) begin miscompares++; $display("FAIL b2b_wlow: got %0d expected 3", low); end
    ahb_do(1'b0, 56'h48, 3'd3, '0, '0, low, lr);
    vectors++;
    if (low !== 2) begin miscompares++; $display("FAIL b2b_rlow: got %0d expected 2", low); end
    vectors++;
    if (ar_first_cyc !== done + 1) begin miscompares++; $display("FAIL b2b_ar_gap: got %0d expected %0d", ar_first_cyc, done + 1); end
    vectors++;
    if (overlap !== 0) begin miscompares++; $display("FAIL b2b_overlap: got %0d expected 0", overlap); end
    vectors++;
    if ({HRDATA, ar_addr_q} !== {64'h0123456789ABCDEF, 31'h48}) begin miscompares++; $display("FAIL b2b_read: got %h/%h expected 0123456789abcdef/48", HRDATA, ar_addr_q); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle_busy();
    test_read_err();
    test_read();
`ifdef AHB_AXI_POSTED_WRITE_EN
    test_posted();
`else
    test_write();
    test_write_err();
    test_back_to_back();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ahb_axi_bridge.md
Name: ahb_axi_bridge

Overview:
- Synthesizable AHB-Lite slave to AXI4 master bridge for the FPGA build, one transfer outstanding at a time.
- Sits between the SoC external AHB port (HSELEXT region) and the AXI clock converter feeding DDR4.
- Replaces the vendor AHB-to-AXI IP so the path can be simulated and modified in-tree.
- Every AHB transfer (any HBURST) becomes one single-beat AXI transaction on the CPU clock.

Parameters:
- AHB_ADDR_WIDTH, 56, width of HADDR.
- AXI_ADDR_WIDTH, 31, width of AXI addresses; HADDR is truncated to its low bits.
- DATA_WIDTH, 64, data width on both buses.
- ID_WIDTH, 4, AXI ID width; the bridge drives ID 0 and ignores BID/RID.

Ports:
- clk  input  1  CPU clock
- reset  input  1  synchronous, active-high
- HSEL, HWRITE, HREADY  input  1 each  AHB select, direction, bus-ready
- HADDR  input  AHB_ADDR_WIDTH  AHB address
- HSIZE, HBURST  input  3 each  AHB size and burst (HBURST is ignored)
- HTRANS  input  2  AHB transfer type
- HPROT  input  4  AHB protection
- HWDATA  input  DATA_WIDTH  write data, valid in data phase
- HWSTRB  input  DATA_WIDTH/8  write strobes, valid in data phase
- HREADYOUT  output  1  slave ready
- HRESP  output  1  slave error
- HRDATA  output  DATA_WIDTH  read data
- m_axi_awid, m_axi_arid  output  ID_WIDTH  constant 0
- m_axi_awaddr, m_axi_araddr  output  AXI_ADDR_WIDTH  transfer address
- m_axi_awlen, m_axi_arlen  output  8  constant 0
- m_axi_awsize, m_axi_arsize  output  3  registered HSIZE
- m_axi_awburst, m_axi_arburst  output  2  constant INCR (01)
- m_axi_awlock, m_axi_arlock  output  1  constant 0
- m_axi_awcache, m_axi_arcache  output  4  constant 0011
- m_axi_awprot, m_axi_arprot  output  3  {~HPROT[0], 1'b0, HPROT[1]}
- m_axi_awvalid/awready, m_axi_arvalid/arready  out/in  1  address handshakes
- m_axi_wdata  output  DATA_WIDTH; m_axi_wstrb  output  DATA_WIDTH/8; m_axi_wlast  output  1  constant 1
- m_axi_wvalid/wready  out/in  1  write-data handshake
- m_axi_bid  input  ID_WIDTH; m_axi_bresp  input  2; m_axi_bvalid  input  1; m_axi_bready  output  1
- m_axi_rid  input  ID_WIDTH; m_axi_rdata  input  DATA_WIDTH; m_axi_rresp  input  2; m_axi_rlast, m_axi_rvalid  input  1; m_axi_rready  output  1

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, all AXI VALID and READY outputs 0, state IDLE. A reset mid-transaction abandons the transfer immediately; the AXI side is reset together with the bridge.
- Transfer start: captured when HSEL & HTRANS[1] & HREADY. HADDR, HWRITE, HSIZE and HPROT are registered.
- A selected IDLE or BUSY transfer gets a zero-wait OKAY.
- FSM states: IDLE, WDATA, WADDR, WRESP, RADDR, RDATA, ERR1, ERR2.
- IDLE: on a captured read, go to RADDR with HREADYOUT=0. On a captured write, go to WDATA with HREADYOUT=0.
- WDATA (one cycle): register HWDATA and HWSTRB, then go to WADDR with AWVALID=1 and WVALID=1.
- WADDR: AWVALID and WVALID each drop independently on their own handshake. When both are done, go to WRESP with BREADY=1.
- WRESP: on BVALID, BREADY drops. If BRESP[1]=0, go to IDLE with HREADYOUT=1 for one cycle; otherwise go to ERR1.
- RADDR: ARVALID=1 until ARREADY, then go to RDATA with RREADY=1.
- RDATA: on RVALID, register RDATA into HRDATA. If RRESP[1]=0, go to IDLE with HREADYOUT=1; otherwise go to ERR1.
- Latency: read = 1 + AR wait + R wait + 1 cycles minimum. With zero-wait slaves, the read data phase lasts 3 cycles and the write data phase lasts 4 cycles.
- Error response (two cycles): ERR1 drives HRESP=1, HREADYOUT=0. ERR2 drives HRESP=1, HREADYOUT=1, then returns to IDLE.
- Pipelined address: the address phase offered while HREADYOUT=1 (final data-phase cycle) is captured in the same cycle with no dead cycle.
- VALID signals never drop before their handshake. Address, data and strobe outputs are stable while VALID is high.
- HRDATA holds its value until the next read completes.

Optional Feature:
- Macro: AHB_AXI_POSTED_WRITE_EN.
- Defined: the write completes on AHB (HREADYOUT=1, OKAY) in the cycle after both the AW and W handshakes. The bridge keeps BREADY=1 and discards B responses, so BRESP errors are not reported.
  - A new transfer stalls in IDLE (HREADYOUT=0 after capture) until the pending B response arrives.
  - At most one B response is outstanding.
- Undefined: the behaviour above applies unchanged.

Decomposition:
- Shared package ahbaxi_pkg holds:
  - the state enum typedef;
  - constants AXI_BURST_INCR=2'b01, AXI_CACHE_DEFAULT=4'b0011, AXI_RESP_SLVERR=2'b10;
  - AHB HTRANS encodings.
- Single module; no sub-module is needed.

Test Plan:
- 8-byte read at 0x8000_0000, with ARREADY and RVALID immediate and RDATA=0xDEADBEEF_CAFEF00D -> ARADDR=0x0000_0000 (31-bit truncation), ARSIZE=3, HRDATA matches, HREADYOUT low for 2 cycles.
- 1-byte write at 0x8000_0003 with HWSTRB=0x08, where AWREADY is delayed 3 cycles and WREADY is immediate -> WVALID drops after 1 cycle, AWVALID is held 4 cycles, WSTRB=0x08, OKAY after BVALID.
- Read with RRESP=2'b10 -> HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1, then IDLE.
- Back-to-back write then read with the read address pipelined in the write's final cycle -> AR issued with no idle gap; AXI VALID signals never overlap between the two transactions.
- Reset asserted in WADDR with AWVALID=1 -> the next cycle has all VALID outputs 0, HREADYOUT=1, HRESP=0.
- With AHB_AXI_POSTED_WRITE_EN defined, write with BVALID delayed 10 cycles -> AHB completes 1 cycle after AW/W; a following read is stalled until BVALID, then proceeds.
